als_seq_unit: RTL and testbench

Parametrised, handshaked arithmetic/logic/shift unit for the datapath. It is the multi-cycle successor of the combined ALU + shift-register block. A single valid/ready front end accepts either an ALU operation, which completes in one cycle, or a shift, which runs iteratively at STEP bits per cycle. The result and comparison flags are held in registers until the consumer takes them. It sits between the register-file read stage and the writeback mux, and it stalls the control FSM through `in_ready`.

---
 rtl/als_pkg.sv | 42 ++++
 rtl/als_iter_shifter.sv | 79 +++++++
 rtl/als_seq_unit.sv | 173 +++++++++++++++++
 tb/tb_als_seq_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/als_pkg.sv
// Shared types for the sequential arithmetic/logic/shift unit:
// opcode enums, FSM states and the registered flag bundle.
package als_pkg;

    typedef enum logic [2:0] {
        ALU_LOAD = 3'b000,
        ALU_ADD  = 3'b001,
        ALU_SUB  = 3'b010,
        ALU_AND  = 3'b011,
        ALU_INC  = 3'b100,
        ALU_NOT  = 3'b101,
        ALU_XOR  = 3'b110,
        ALU_CMP  = 3'b111
    } alu_op_t;

    typedef enum logic [2:0] {
        SH_PASS  = 3'b000,
        SH_LOAD  = 3'b001,
        SH_SLL   = 3'b010,
        SH_SRL   = 3'b011,
        SH_SRA   = 3'b100,
        SH_ROR   = 3'b101,
        SH_ROL   = 3'b110,
        SH_PASS2 = 3'b111
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic ovf;
        logic neg;
        logic zero;
        logic eq;
        logic gt;
        logic lt;
    } flags_t;

endpackage

// File: rtl/als_iter_shifter.sv
// Iterative shifter: working register plus remaining-count register,
// advancing min(STEP, remaining) bits per enabled cycle.
// Ports: clk, rst (async, active-high), load (capture data/op/shamt),
//   step (advance one iteration), op, shamt, data,
//   value (working register after the current step, combinational),
//   done (the current step is the last one).
// Rotates exist only when ALS_ROTATE_EN is defined.
module als_iter_shifter
    import als_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  shift_op_t        op,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] value,
    output logic             done
);

    localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);

    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   rem;
    logic [SHW-1:0]   amt;
    shift_op_t        op_q;

    // amt only takes STEP when STEP <= rem < WIDTH, so it fits SHW bits
    always_comb begin
        if ({1'b0, rem} < STEP_W) begin
            amt = rem;
        end else begin
            amt = STEP_W[SHW-1:0];
        end
    end

    assign done = ({1'b0, rem} <= STEP_W);

`ifdef ALS_ROTATE_EN
    localparam logic [SHW:0] WIDTH_W = (SHW+1)'(WIDTH);
    logic [SHW:0] inv;
    assign inv = WIDTH_W - {1'b0, amt};
`endif

    always_comb begin
        value = work;
        case (op_q)
            SH_SLL: value = work << amt;
            SH_SRL: value = work >> amt;
            SH_SRA: value = WIDTH'($signed(work) >>> amt);
`ifdef ALS_ROTATE_EN
            SH_ROR: value = (work >> amt) | (work << inv);
            SH_ROL: value = (work << amt) | (work >> inv);
`endif
            default: value = work;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work <= '0;
            rem  <= '0;
            op_q <= SH_PASS;
        end else if (load) begin
            work <= data;
            rem  <= shamt;
            op_q <= op;
        end else if (step) begin
            work <= value;
            rem  <= rem - amt;
        end
    end

endmodule

// File: rtl/als_seq_unit.sv
// Handshaked ALU + iterative shifter with registered result and flags.
// Ports: Clk, reset (async, active-high); in_valid/in_ready request;
//   mode (0 ALU, 1 shift), alu_sel, shift_op, shamt, oper_a, oper_b;
//   out_valid/out_ready result; result and six flags; busy in SHIFT.
// Define ALS_ROTATE_EN to enable ROR/ROL; otherwise they act as pass.
module als_seq_unit
    import als_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [2:0]       alu_sel,
    input  logic [2:0]       shift_op,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] oper_a,
    input  logic [WIDTH-1:0] oper_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             negative,
    output logic             zero,
    output logic             equal,
    output logic             greater,
    output logic             lesser,
    output logic             busy
);

    localparam int M = WIDTH - 1;

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             quick;
    logic             sh_load;
    logic             sh_done;
    logic [WIDTH-1:0] sh_value;
    logic [WIDTH-1:0] alu_r;
    logic             alu_ov;
    logic [WIDTH-1:0] result_q;
    flags_t           flags_q;
    alu_op_t          aop;
    shift_op_t        sop;

    assign aop = alu_op_t'(alu_sel);
    assign sop = shift_op_t'(shift_op);

    always_comb begin
        alu_r  = '0;
        alu_ov = 1'b0;
        case (aop)
            ALU_LOAD: alu_r = oper_a;
            ALU_ADD: begin
                alu_r  = oper_a + oper_b;
                alu_ov = (oper_a[M] == oper_b[M]) && (alu_r[M] != oper_a[M]);
            end
            ALU_SUB: begin
                alu_r  = oper_a - oper_b;
                alu_ov = (oper_a[M] != oper_b[M]) && (alu_r[M] != oper_a[M]);
            end
            ALU_AND: alu_r = oper_a & oper_b;
            ALU_INC: begin
                alu_r  = oper_a + WIDTH'(1);
                alu_ov = !oper_a[M] && alu_r[M];
            end
            ALU_NOT: alu_r = ~oper_a;
            ALU_XOR: alu_r = oper_a ^ oper_b;
            default: alu_r = '0;
        endcase
    end

    // Shifts that finish without iterating: result is simply oper_a
    always_comb begin
        quick = 1'b0;
        case (sop)
            SH_PASS, SH_LOAD, SH_PASS2: quick = 1'b1;
`ifndef ALS_ROTATE_EN
            SH_ROR, SH_ROL: quick = 1'b1;
`endif
            default: quick = 1'b0;
        endcase
        if (shamt == '0) begin
            quick = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
        accept   = in_valid && in_ready;
        sh_load  = accept && mode && !quick;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = sh_load ? SHIFT : DONE;
                end else if (state_q == DONE && out_ready) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (sh_done) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            flags_q  <= '0;
        end else if (accept && !mode) begin
            result_q     <= alu_r;
            flags_q.ovf  <= alu_ov;
            flags_q.neg  <= alu_r[M];
            flags_q.zero <= (alu_r == '0);
            flags_q.eq   <= (oper_a == oper_b);
            flags_q.gt   <= ($signed(oper_a) > $signed(oper_b));
            flags_q.lt   <= ($signed(oper_a) < $signed(oper_b));
        end else if (accept && quick) begin
            result_q     <= oper_a;
            flags_q      <= '0;
            flags_q.neg  <= oper_a[M];
            flags_q.zero <= (oper_a == '0);
        end else if (state_q == SHIFT && sh_done) begin
            result_q     <= sh_value;
            flags_q      <= '0;
            flags_q.neg  <= sh_value[M];
            flags_q.zero <= (sh_value == '0);
        end
    end

    als_iter_shifter #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_shift (
        .clk   (Clk),
        .rst   (reset),
        .load  (sh_load),
        .step  (state_q == SHIFT),
        .op    (sop),
        .shamt (shamt),
        .data  (oper_a),
        .value (sh_value),
        .done  (sh_done)
    );

    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == SHIFT);
    assign result    = result_q;
    assign overflow  = flags_q.ovf;
    assign negative  = flags_q.neg;
    assign zero      = flags_q.zero;
    assign equal     = flags_q.eq;
    assign greater   = flags_q.gt;
    assign lesser    = flags_q.lt;

endmodule

// File: tb/tb_als_seq_unit.sv
// Scoreboard bench for als_seq_unit: instance 0 uses STEP=1,
// instance 1 uses STEP=4; expected values are hand-computed.
module tb_als_seq_unit;

    typedef struct {
        logic [31:0] r;
        logic [5:0]  f;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv   [2];
    logic        ir   [2];
    logic        md   [2];
    logic [2:0]  sel  [2];
    logic [4:0]  shv  [2];
    logic [31:0] a    [2];
    logic [31:0] b    [2];
    logic        ov   [2];
    logic        ordy [2];
    logic [31:0] res  [2];
    logic        fo   [2];
    logic        fn   [2];
    logic        fz   [2];
    logic        fe   [2];
    logic        fg   [2];
    logic        fl   [2];
    logic        bsy  [2];

    exp_t q0[$];
    exp_t q1[$];
    exp_t me;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   bc       [2];
    bit   first    [2];
    int   a1, a2, acc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    als_seq_unit #(.WIDTH(32), .STEP(1)) u0 (
        .Clk(clk), .reset(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .mode(md[0]), .alu_sel(sel[0]), .shift_op(sel[0]),
        .shamt(shv[0]), .oper_a(a[0]), .oper_b(b[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .result(res[0]),
        .overflow(fo[0]), .negative(fn[0]), .zero(fz[0]),
        .equal(fe[0]), .greater(fg[0]), .lesser(fl[0]), .busy(bsy[0])
    );

    als_seq_unit #(.WIDTH(32), .STEP(4)) u1 (
        .Clk(clk), .reset(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .mode(md[1]), .alu_sel(sel[1]), .shift_op(sel[1]),
        .shamt(shv[1]), .oper_a(a[1]), .oper_b(b[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .result(res[1]),
        .overflow(fo[1]), .negative(fn[1]), .zero(fz[1]),
        .equal(fe[1]), .greater(fg[1]), .lesser(fl[1]), .busy(bsy[1])
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [5:0] flags(input int w);
        return {fo[w], fn[w], fz[w], fe[w], fg[w], fl[w]};
    endfunction

    // Monitor: sample mid-low-phase, after all negedge-driven inputs settle
    always begin
        @(negedge clk);
        #2;
        for (int w = 0; w < 2; w++) begin
            if (rst) begin
                bc[w]    = 0;
                first[w] = 1'b1;
            end else begin
                if (bsy[w]) bc[w]++;
                if (ov[w]) begin
                    if ((w == 0 ? q0.size() : q1.size()) == 0) begin
                        chk($sformatf("u%0d_unexpected_valid", w), 32'd1, 32'd0);
                    end else begin
                        me = (w == 0) ? q0[0] : q1[0];
                        if (first[w]) begin
                            chk($sformatf("u%0d_latency", w), 32'(cyc - me.acc), 32'(me.lat));
                            chk($sformatf("u%0d_busy_cycles", w), 32'(bc[w]), 32'(me.lat));
                        end
                        chk($sformatf("u%0d_result", w), res[w], me.r);
                        chk($sformatf("u%0d_flags", w), {26'd0, flags(w)}, {26'd0, me.f});
                        first[w] = 1'b0;
                        if (ordy[w]) begin
                            if (w == 0) void'(q0.pop_front());
                            else void'(q1.pop_front());
                            first[w] = 1'b1;
                            bc[w]    = 0;
                        end
                    end
                end
            end
        end
    end

    // Call at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input int w, input logic m, input logic [2:0] s,
                         input logic [31:0] aa, input logic [31:0] bb,
                         input logic [4:0] n, input logic [31:0] er,
                         input logic [5:0] ef, input int lat,
                         input bit push, output int acc_o);
        int   t = 0;
        exp_t e;
        md[w]  = m;
        sel[w] = s;
        a[w]   = aa;
        b[w]   = bb;
        shv[w] = n;
        iv[w]  = 1'b1;
        while (!ir[w] && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ir[w]) begin
            chk($sformatf("u%0d_accept_timeout", w), 32'd0, 32'd1);
            iv[w] = 1'b0;
            acc_o = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc_o = cyc;
        if (push) begin
            e.r   = er;
            e.f   = ef;
            e.lat = lat;
            e.acc = cyc;
            if (w == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        @(negedge clk);
        iv[w] = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 400) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("drain_queues", 32'(q0.size() + q1.size()), 32'd0);
    endtask

    initial begin
        for (int w = 0; w < 2; w++) begin
            iv[w]   = 1'b0;
            md[w]   = 1'b0;
            sel[w]  = 3'd0;
            shv[w]  = 5'd0;
            a[w]    = '0;
            b[w]    = '0;
            ordy[w] = 1'b1;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, ov[0]}, 32'd0);
        chk("rst_result", res[0], 32'd0);
        chk("rst_flags", {26'd0, flags(0)}, 32'd0);
        chk("rst_in_ready", {31'd0, ir[0]}, 32'd1);
        chk("rst_busy", {31'd0, bsy[0]}, 32'd0);
        @(negedge clk);

        // ALU ops, STEP=1 instance
        issue(0, 0, 3'b001, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 6'b110010, 0, 1, acc);
        issue(0, 0, 3'b010, 32'h80000000, 32'h1, 0, 32'h7FFFFFFF, 6'b100001, 0, 1, acc);
        issue(0, 0, 3'b011, 32'hFF00FF00, 32'h0F0F0F0F, 0, 32'h0F000F00, 6'b000001, 0, 1, acc);
        issue(0, 0, 3'b100, 32'hFFFFFFFF, 32'h0, 0, 32'h0, 6'b001001, 0, 1, acc);
        issue(0, 0, 3'b101, 32'h0, 32'h0, 0, 32'hFFFFFFFF, 6'b010100, 0, 1, acc);
        issue(0, 0, 3'b110, 32'hAAAA5555, 32'hFFFF0000, 0, 32'h55555555, 6'b000001, 0, 1, acc);
        issue(0, 0, 3'b111, 32'h3, 32'hFFFFFFFE, 0, 32'h0, 6'b001010, 0, 1, acc);

        // Shifts, STEP=1 instance
        issue(0, 1, 3'b100, 32'hF0000000, 32'h0, 4, 32'hFF000000, 6'b010000, 4, 1, acc);
        issue(0, 1, 3'b011, 32'h80000000, 32'h0, 31, 32'h00000001, 6'b000000, 31, 1, acc);
        issue(0, 1, 3'b010, 32'h5, 32'h0, 0, 32'h5, 6'b000000, 0, 1, acc);
        issue(0, 1, 3'b000, 32'h80000000, 32'h0, 5, 32'h80000000, 6'b010000, 0, 1, acc);
        issue(0, 1, 3'b001, 32'h0, 32'h0, 3, 32'h0, 6'b001000, 0, 1, acc);
`ifdef ALS_ROTATE_EN
        issue(0, 1, 3'b101, 32'h1, 32'h0, 4, 32'h10000000, 6'b000000, 4, 1, acc);
        issue(0, 1, 3'b110, 32'h80000001, 32'h0, 1, 32'h00000003, 6'b000000, 1, 1, acc);
`else
        issue(0, 1, 3'b101, 32'h1, 32'h0, 4, 32'h1, 6'b000000, 0, 1, acc);
        issue(0, 1, 3'b110, 32'h80000001, 32'h0, 1, 32'h80000001, 6'b010000, 0, 1, acc);
`endif

        // Shifts, STEP=4 instance
        issue(1, 1, 3'b100, 32'hF0000000, 32'h0, 4, 32'hFF000000, 6'b010000, 1, 1, acc);
        issue(1, 1, 3'b100, 32'hF0000000, 32'h0, 6, 32'hFFC00000, 6'b010000, 2, 1, acc);
        issue(1, 1, 3'b011, 32'hF0000000, 32'h0, 5, 32'h07800000, 6'b000000, 2, 1, acc);
        issue(1, 1, 3'b010, 32'h1, 32'h0, 31, 32'h80000000, 6'b010000, 8, 1, acc);
`ifdef ALS_ROTATE_EN
        issue(1, 1, 3'b101, 32'h1, 32'h0, 6, 32'h04000000, 6'b000000, 2, 1, acc);
`else
        issue(1, 1, 3'b101, 32'h1, 32'h0, 6, 32'h1, 6'b000000, 0, 1, acc);
`endif
        drain();

        // Result held while consumer stalls
        ordy[0] = 1'b0;
        issue(0, 0, 3'b010, 32'h5, 32'h5, 0, 32'h0, 6'b001100, 0, 1, acc);
        repeat (3) begin
            chk("hold_in_ready", {31'd0, ir[0]}, 32'd0);
            @(negedge clk);
        end
        ordy[0] = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, ir[0]}, 32'd1);
        @(negedge clk);
        drain();

        // Back-to-back: second request accepted in first's DONE cycle
        issue(0, 0, 3'b000, 32'h12, 32'h34, 0, 32'h12, 6'b000001, 0, 1, a1);
        issue(0, 1, 3'b010, 32'h1, 32'h0, 31, 32'h80000000, 6'b010000, 31, 1, a2);
        chk("b2b_gap", 32'(a2 - a1), 32'd1);
        drain();

        // Reset in the middle of a shift discards it
        issue(0, 1, 3'b011, 32'hFFFFFFFF, 32'h0, 20, 32'h0, 6'b0, 0, 0, acc);
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", {31'd0, bsy[0]}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'd0, ov[0]}, 32'd0);
        chk("mid_rst_result", res[0], 32'd0);
        chk("mid_rst_flags", {26'd0, flags(0)}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, ir[0]}, 32'd1);
        chk("mid_rst_busy", {31'd0, bsy[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("post_rst_no_valid", {31'd0, ov[0]}, 32'd0);
        issue(0, 0, 3'b001, 32'h2, 32'h3, 0, 32'h5, 6'b000001, 0, 1, acc);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
